// File: rtl/rv32_decode.sv
// RV32I decode stage: register-file read addresses, immediate generation,
// control class and a single-cycle load-use bubble.
module rv32_decode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic        hazard_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] imm_out,
  output logic [2:0]  funct3_out,
  output logic        alt_out,
  output logic [3:0]  class_out,
  output logic        illegal_out
);

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LUI    = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_JAL    = 4'd3,
    CLS_JALR   = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_OPIMM  = 4'd8,
    CLS_OP     = 4'd9,
    CLS_MISC   = 4'd10,
    CLS_SYSTEM = 4'd11
  } cls_e;

  cls_e        dec_class;
  logic        dec_unknown;
  logic        dec_writes;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;

  assign rs1_out = instr_in[19:15];
  assign rs2_out = instr_in[24:20];
  assign dec_rd  = instr_in[11:7];

  // The full 7-bit opcode includes instr[1:0], so compressed encodings fall
  // through to the unknown case without a separate check.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec_class   = CLS_NONE;
    dec_unknown = 1'b0;
    unique case (instr_in[6:0])
      7'b0110111: dec_class = CLS_LUI;
      7'b0010111: dec_class = CLS_AUIPC;
      7'b1101111: dec_class = CLS_JAL;
      7'b1100111: dec_class = CLS_JALR;
      7'b1100011: dec_class = CLS_BRANCH;
      7'b0000011: dec_class = CLS_LOAD;
      7'b0100011: dec_class = CLS_STORE;
      7'b0010011: dec_class = CLS_OPIMM;
      7'b0110011: dec_class = CLS_OP;
      7'b0001111: dec_class = CLS_MISC;
      7'b1110011: dec_class = CLS_SYSTEM;
      default:    dec_unknown = 1'b1;
    endcase
  end

  always_comb begin
    dec_imm    = 32'd0;
    dec_writes = 1'b0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    case (dec_class)
      CLS_LUI, CLS_AUIPC: begin
        dec_imm    = {instr_in[31:12], 12'b0};
        dec_writes = 1'b1;
      end
      CLS_JAL: begin
        dec_imm    = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20],
                      instr_in[30:21], 1'b0};
        dec_writes = 1'b1;
      end
      CLS_JALR, CLS_LOAD, CLS_OPIMM: begin
        dec_imm    = {{20{instr_in[31]}}, instr_in[31:20]};
        dec_writes = 1'b1;
        uses_rs1   = 1'b1;
      end
      CLS_SYSTEM: begin
        dec_imm    = {{20{instr_in[31]}}, instr_in[31:20]};
        dec_writes = 1'b1;
      end
      CLS_BRANCH: begin
        dec_imm  = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      CLS_STORE: begin
        dec_imm  = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      CLS_OP: begin
        dec_writes = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      default: ;
    endcase
  end

  // Computed from the held registered state, so it may assert during a stall.
  assign hazard_out = valid_in && valid_out && (class_out == CLS_LOAD) &&
                      (rd_out != 5'd0) &&
                      ((uses_rs1 && (rs1_out == rd_out)) ||
                       (uses_rs2 && (rs2_out == rd_out)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out    <= 1'b0;
      pc_out       <= 32'd0;
      rd_out       <= 5'd0;
      rd_write_out <= 1'b0;
      imm_out      <= 32'd0;
      funct3_out   <= 3'd0;
      alt_out      <= 1'b0;
      class_out    <= CLS_NONE;
      illegal_out  <= 1'b0;
    end else if (flush_in || (!stall_in && hazard_out)) begin
      valid_out    <= 1'b0;
      rd_write_out <= 1'b0;
      class_out    <= CLS_NONE;
      illegal_out  <= 1'b0;
    end else if (!stall_in) begin
      valid_out    <= valid_in;
      pc_out       <= pc_in;
      rd_out       <= dec_rd;
      rd_write_out <= valid_in && dec_writes && (dec_rd != 5'd0);
      imm_out      <= dec_imm;
      funct3_out   <= instr_in[14:12];
      alt_out      <= instr_in[30];
      class_out    <= valid_in ? dec_class : CLS_NONE;
      illegal_out  <= valid_in && dec_unknown;
    end
  end

endmodule

// File: tb/tb_rv32_decode.sv
// Directed self-checking bench for rv32_decode with hand-computed expectations.
module tb_rv32_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in;
  logic        flush_in;
  logic        valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic        hazard_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] imm_out;
  logic [2:0]  funct3_out;
  logic        alt_out;
  logic [3:0]  class_out;
  logic        illegal_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_decode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .valid_in     (valid_in),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .rs1_out      (rs1_out),
    .rs2_out      (rs2_out),
    .hazard_out   (hazard_out),
    .valid_out    (valid_out),
    .pc_out       (pc_out),
    .rd_out       (rd_out),
    .rd_write_out (rd_write_out),
    .imm_out      (imm_out),
    .funct3_out   (funct3_out),
    .alt_out      (alt_out),
    .class_out    (class_out),
    .illegal_out  (illegal_out)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    valid_in = 1'b1;
    instr_in = instr;
    pc_in    = pc;
  endtask

  initial begin
    reset_n  = 1'b0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    valid_in = 1'b0;
    instr_in = 32'd0;
    pc_in    = 32'd0;
    tick();
    tick();
    check("rst_valid", valid_out, 0);
    check("rst_class", class_out, 0);
    check("rst_imm", imm_out, 0);
    check("rst_hazard", hazard_out, 0);
    reset_n = 1'b1;
    tick();

    // addi x1,x0,-1
    drive(32'hFFF00093, 32'h100);
    #1;
    check("addi_rs1_comb", rs1_out, 0);
    check("addi_rs2_comb", rs2_out, 31);
    tick();
    check("addi_valid", valid_out, 1);
    check("addi_class", class_out, 8);
    check("addi_rd", rd_out, 1);
    check("addi_rdw", rd_write_out, 1);
    check("addi_imm", imm_out, 32'hFFFFFFFF);
    check("addi_pc", pc_out, 32'h100);

    // jal x1,-1MiB
    drive(32'h800000EF, 32'h104);
    tick();
    check("jal_class", class_out, 3);
    check("jal_imm", imm_out, 32'hFFF00000);
    check("jal_rdw", rd_write_out, 1);

    // bne x1,x2,-4
    drive(32'hFE209EE3, 32'h108);
    #1;
    check("bne_rs1_comb", rs1_out, 1);
    check("bne_rs2_comb", rs2_out, 2);
    tick();
    check("bne_class", class_out, 5);
    check("bne_imm", imm_out, 32'hFFFFFFFC);
    check("bne_rdw", rd_write_out, 0);
    check("bne_funct3", funct3_out, 1);

    // nop: rd = x0
    drive(32'h00000013, 32'h10C);
    tick();
    check("nop_valid", valid_out, 1);
    check("nop_rdw", rd_write_out, 0);

    // sub x3,x1,x2
    drive(32'h402081B3, 32'h110);
    tick();
    check("sub_class", class_out, 9);
    check("sub_alt", alt_out, 1);
    check("sub_rd", rd_out, 3);
    check("sub_imm", imm_out, 0);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h114);
    tick();
    check("sw_class", class_out, 7);
    check("sw_imm", imm_out, 8);
    check("sw_rdw", rd_write_out, 0);

    // lui x5,0x12345
    drive(32'h123452B7, 32'h118);
    tick();
    check("lui_class", class_out, 1);
    check("lui_imm", imm_out, 32'h12345000);
    check("lui_rdw", rd_write_out, 1);

    // Unknown opcode, then compressed-style low bits
    drive(32'h0000007F, 32'h11C);
    tick();
    check("ill_valid", valid_out, 1);
    check("ill_flag", illegal_out, 1);
    check("ill_class", class_out, 0);
    check("ill_rdw", rd_write_out, 0);
    drive(32'h00000091, 32'h120);
    tick();
    check("ill_lowbits", illegal_out, 1);

    // valid_in low registers a bubble
    valid_in = 1'b0;
    tick();
    check("bub_valid", valid_out, 0);
    check("bub_ill", illegal_out, 0);

    // lw x5,0(x1) ; add x6,x5,x7 -> one bubble
    drive(32'h0000A283, 32'h200);
    tick();
    check("lw_class", class_out, 6);
    check("lw_rd", rd_out, 5);
    drive(32'h00728333, 32'h204);
    #1;
    check("lu_hazard", hazard_out, 1);
    check("lu_rs1", rs1_out, 5);
    tick();
    check("lu_bubble_valid", valid_out, 0);
    check("lu_bubble_class", class_out, 0);
    check("lu_bubble_rdw", rd_write_out, 0);
    check("lu_hazard_clear", hazard_out, 0);
    tick();
    check("lu_issue_valid", valid_out, 1);
    check("lu_issue_class", class_out, 9);
    check("lu_issue_rd", rd_out, 6);
    check("lu_issue_pc", pc_out, 32'h204);

    // lw x5,0(x1) ; add x6,x7,x8 -> no hazard
    drive(32'h0000A283, 32'h208);
    tick();
    drive(32'h00838333, 32'h20C);
    #1;
    check("nohz_hazard", hazard_out, 0);
    tick();
    check("nohz_valid", valid_out, 1);
    check("nohz_pc", pc_out, 32'h20C);

    // lw x0 ; add x6,x0,x0 -> rd=x0 never stalls
    drive(32'h0000A003, 32'h210);
    tick();
    drive(32'h00000333, 32'h214);
    #1;
    check("x0_hazard", hazard_out, 0);
    tick();

    // Stall holds everything for three cycles
    drive(32'h402081B3, 32'h300);
    tick();
    stall_in = 1'b1;
    drive(32'hFFF00093, 32'h400);
    tick();
    tick();
    tick();
    check("stall_pc", pc_out, 32'h300);
    check("stall_class", class_out, 9);
    check("stall_rd", rd_out, 3);
    check("stall_alt", alt_out, 1);
    check("stall_imm", imm_out, 0);
    stall_in = 1'b0;
    tick();
    check("unstall_pc", pc_out, 32'h400);
    check("unstall_imm", imm_out, 32'hFFFFFFFF);

    // Flush with a valid instruction
    flush_in = 1'b1;
    drive(32'hFFF00093, 32'h404);
    tick();
    check("flush_valid", valid_out, 0);
    check("flush_rdw", rd_write_out, 0);
    check("flush_class", class_out, 0);
    flush_in = 1'b0;

    // Flush and hazard together
    drive(32'h0000A283, 32'h500);
    tick();
    drive(32'h00728333, 32'h504);
    flush_in = 1'b1;
    #1;
    check("fh_hazard", hazard_out, 1);
    tick();
    check("fh_valid", valid_out, 0);
    check("fh_class", class_out, 0);
    check("fh_hazard_next", hazard_out, 0);
    flush_in = 1'b0;
    tick();
    check("fh_issue_valid", valid_out, 1);
    check("fh_issue_class", class_out, 9);

    // Asynchronous reset mid-stream
    drive(32'hFFF00093, 32'h600);
    tick();
    check("pre_rst_valid", valid_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", valid_out, 0);
    check("arst_pc", pc_out, 0);
    check("arst_rd", rd_out, 0);
    check("arst_rdw", rd_write_out, 0);
    check("arst_imm", imm_out, 0);
    check("arst_class", class_out, 0);
    check("arst_hazard", hazard_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
